// File: rtl/s1_pontuacao.sv
// Scoring datapath: round error counter, per-round error memory, saturating points
// register and an iterative double-dabble converter feeding three BCD digits.
module s1_pontuacao #(
    parameter int unsigned N_RODADAS  = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned ERR_W      = 4,
    parameter int unsigned PONTOS_INI = 100,
    parameter int unsigned PESO       = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zeraErro,
    input  logic              contaErro,
    input  logic              zeraMemErro,
    input  logic              regErro,
    input  logic [ADDR_W-1:0] endereco,
    input  logic              zeraPontos,
    input  logic              regPontos,
    output logic [ERR_W-1:0]  erros_rodada,
    output logic [ERR_W-1:0]  erro_lido,
    output logic [6:0]        pontos,
    output logic [3:0]        bcd_centena,
    output logic [3:0]        bcd_dezena,
    output logic [3:0]        bcd_unidade,
    output logic              bcd_valido
);

    localparam int unsigned PW = 7 + ERR_W;

    typedef enum logic [1:0] {StOcioso, StConverte, StPronto} estado_e;

    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] mem_q [N_RODADAS];
    logic [ERR_W-1:0] mem_d [N_RODADAS];
    logic [6:0]       pontos_q, pontos_d;
    logic             addr_ok;
    logic             pontos_wr;
    logic [PW-1:0]    penalidade;
    logic [PW-1:0]    pontos_ext;

    estado_e          estado_q, estado_d;
    logic [6:0]       bin_q, bin_d;
    logic [11:0]      acc_q, acc_d, acc_corr;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       centena_q, centena_d, dezena_q, dezena_d, unidade_q, unidade_d;
    logic             valido_q, valido_d;

    assign addr_ok    = (32'(endereco) < N_RODADAS);
    assign erro_lido  = addr_ok ? mem_q[endereco] : '0;
    assign penalidade = PW'(erro_lido) * PW'(PESO);
    assign pontos_ext = PW'(pontos_q);
    assign pontos_wr  = zeraPontos | regPontos;

    always_comb begin
        err_d = err_q;
        if (zeraErro) begin
            err_d = '0;
        end else if (contaErro && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    // regErro stores the pre-edge count, so a same-cycle increment is not captured
    always_comb begin
        mem_d = mem_q;
        if (zeraMemErro) begin
            for (int i = 0; i < int'(N_RODADAS); i++) begin
                mem_d[i] = '0;
            end
        end else if (regErro && addr_ok) begin
            mem_d[endereco] = err_q;
        end
    end

    always_comb begin
        pontos_d = pontos_q;
        if (zeraPontos) begin
            pontos_d = 7'(PONTOS_INI);
        end else if (regPontos) begin
            pontos_d = (penalidade >= pontos_ext) ? 7'd0 : (pontos_q - penalidade[6:0]);
        end
    end

    always_comb begin
        acc_corr = acc_q;
        for (int k = 0; k < 3; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_corr[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        estado_d  = estado_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        centena_d = centena_q;
        dezena_d  = dezena_q;
        unidade_d = unidade_q;
        valido_d  = valido_q;
        unique case (estado_q)
            StOcioso: begin
            end
            StConverte: begin
                acc_d = {acc_corr[10:0], bin_q[6]};
                bin_d = {bin_q[5:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    estado_d = StPronto;
                end
            end
            StPronto: begin
                centena_d = acc_q[11:8];
                dezena_d  = acc_q[7:4];
                unidade_d = acc_q[3:0];
                valido_d  = 1'b1;
                estado_d  = StOcioso;
            end
            default: estado_d = StOcioso;
        endcase
        // A points write always (re)starts conversion on the new value
        if (pontos_wr) begin
            estado_d = StConverte;
            bin_d    = pontos_d;
            acc_d    = '0;
            cnt_d    = '0;
            valido_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q    <= '0;
            pontos_q <= '0;
            for (int i = 0; i < int'(N_RODADAS); i++) begin
                mem_q[i] <= '0;
            end
            estado_q  <= StOcioso;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            centena_q <= '0;
            dezena_q  <= '0;
            unidade_q <= '0;
            valido_q  <= 1'b1;
        end else begin
            err_q    <= err_d;
            pontos_q <= pontos_d;
            for (int i = 0; i < int'(N_RODADAS); i++) begin
                mem_q[i] <= mem_d[i];
            end
            estado_q  <= estado_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            centena_q <= centena_d;
            dezena_q  <= dezena_d;
            unidade_q <= unidade_d;
            valido_q  <= valido_d;
        end
    end

    assign erros_rodada = err_q;
    assign pontos       = pontos_q;
    assign bcd_centena  = centena_q;
    assign bcd_dezena   = dezena_q;
    assign bcd_unidade  = unidade_q;
    assign bcd_valido   = valido_q;

endmodule

// File: tb/tb_s1_pontuacao.sv
// Directed bench for s1_pontuacao: a cycle model tracks errors, memory and points, and
// expected BCD results are queued at each points write and popped when bcd_valido rises.
module tb_s1_pontuacao;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraErro, contaErro, zeraMemErro, regErro, zeraPontos, regPontos;
    logic [3:0] endereco;
    logic [3:0] erros_rodada, erro_lido;
    logic [6:0] pontos;
    logic [3:0] bcd_centena, bcd_dezena, bcd_unidade;
    logic       bcd_valido;

    int n_assert = 0;
    int n_fail   = 0;
    int err_m    = 0;
    int pts_m    = 0;
    int mem_m [16];
    int exp_q [$];
    int since_wr = 0;

    s1_pontuacao dut (
        .clock        (clock),
        .reset        (reset),
        .zeraErro     (zeraErro),
        .contaErro    (contaErro),
        .zeraMemErro  (zeraMemErro),
        .regErro      (regErro),
        .endereco     (endereco),
        .zeraPontos   (zeraPontos),
        .regPontos    (regPontos),
        .erros_rodada (erros_rodada),
        .erro_lido    (erro_lido),
        .pontos       (pontos),
        .bcd_centena  (bcd_centena),
        .bcd_dezena   (bcd_dezena),
        .bcd_unidade  (bcd_unidade),
        .bcd_valido   (bcd_valido)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic idle();
        zeraErro = 0; contaErro = 0; zeraMemErro = 0; regErro = 0;
        zeraPontos = 0; regPontos = 0;
    endtask

    // Advance one clock, stepping the reference model with the currently driven inputs
    task automatic tick();
        int lido;
        if (!reset) begin
            err_m = 0;
            pts_m = 0;
            foreach (mem_m[i]) mem_m[i] = 0;
            exp_q.delete();
        end else begin
            lido = mem_m[endereco];
            if (zeraMemErro) foreach (mem_m[i]) mem_m[i] = 0;
            else if (regErro) mem_m[endereco] = err_m;
            if (zeraErro) err_m = 0;
            else if (contaErro && err_m < 15) err_m++;
            if (zeraPontos) pts_m = 100;
            else if (regPontos) pts_m = (lido * 2 >= pts_m) ? 0 : pts_m - lido * 2;
            if (zeraPontos || regPontos) begin
                exp_q.delete();
                exp_q.push_back(pts_m);
                since_wr = -1;
            end
        end
        @(posedge clock);
        #1;
        since_wr++;
    endtask

    task automatic wait_bcd(input string tag);
        int n = 0;
        int d0;
        int v;
        d0 = bcd_centena * 100 + bcd_dezena * 10 + bcd_unidade;
        while (bcd_valido !== 1'b1 && n < 20) begin
            chk({tag, "_hold"}, bcd_centena * 100 + bcd_dezena * 10 + bcd_unidade, d0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, since_wr, 8);
        chk({tag, "_queue"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            chk({tag, "_centena"}, bcd_centena, v / 100);
            chk({tag, "_dezena"}, bcd_dezena, (v / 10) % 10);
            chk({tag, "_unidade"}, bcd_unidade, v % 10);
        end
    endtask

    task automatic chk_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            endereco = 4'(a);
            #1;
            chk(tag, erro_lido, mem_m[a]);
        end
    endtask

    initial begin
        idle();
        endereco = 0;
        reset = 0;
        tick();
        tick();
        chk("rst_pontos", pontos, 0);
        chk("rst_centena", bcd_centena, 0);
        chk("rst_dezena", bcd_dezena, 0);
        chk("rst_unidade", bcd_unidade, 0);
        chk("rst_valido", bcd_valido, 1);
        chk("rst_erros", erros_rodada, 0);
        chk_mem("rst_mem");
        reset = 1;

        // Round errors: 3 at round 2, saturated 15 at round 5
        zeraErro = 1; tick(); zeraErro = 0;
        contaErro = 1; repeat (3) tick(); contaErro = 0;
        chk("err_cnt3", erros_rodada, err_m);
        endereco = 2; regErro = 1; tick(); regErro = 0;
        zeraErro = 1; tick(); zeraErro = 0;
        contaErro = 1; repeat (20) tick(); contaErro = 0;
        chk("err_sat", erros_rodada, 15);
        endereco = 5; regErro = 1; tick(); regErro = 0;
        endereco = 2; #1; chk("mem2", erro_lido, 3);
        endereco = 5; #1; chk("mem5", erro_lido, 15);

        // regErro with contaErro stores the pre-increment count
        zeraErro = 1; tick(); zeraErro = 0;
        contaErro = 1; tick();
        endereco = 7; regErro = 1; tick(); regErro = 0; contaErro = 0;
        chk("reg_pre_inc_cnt", erros_rodada, 2);
        chk_mem("mem_after_errs");

        // Scoring 100 -> 94 -> 64
        zeraPontos = 1; tick(); zeraPontos = 0;
        chk("pts_ini", pontos, pts_m);
        chk("valido_low", bcd_valido, 0);
        endereco = 2; #1; regPontos = 1; tick();
        chk("pts_94", pontos, pts_m);
        endereco = 5; #1; tick(); regPontos = 0;
        chk("pts_64", pontos, pts_m);
        tick();
        chk("pts_hold", pontos, pts_m);
        wait_bcd("bcd64");

        // Restart mid-conversion: only the second value (70) is presented
        zeraPontos = 1; tick(); zeraPontos = 0;
        tick(); tick();
        chk("mid_valido", bcd_valido, 0);
        endereco = 5; #1; regPontos = 1; tick(); regPontos = 0;
        chk("pts_70", pontos, pts_m);
        wait_bcd("bcd70");

        // Penalty larger than score saturates at zero
        zeraErro = 1; tick(); zeraErro = 0;
        contaErro = 1; repeat (15) tick(); contaErro = 0;
        regErro = 1;
        for (int a = 0; a < 16; a++) begin
            endereco = 4'(a);
            tick();
        end
        regErro = 0;
        zeraPontos = 1; tick(); zeraPontos = 0;
        regPontos = 1;
        for (int a = 0; a < 16; a++) begin
            endereco = 4'(a);
            tick();
            chk("pts_sat", pontos, pts_m);
        end
        regPontos = 0;
        wait_bcd("bcd0");

        // zeraMemErro beats a same-cycle regErro
        endereco = 3; zeraMemErro = 1; regErro = 1; tick(); idle();
        chk_mem("mem_clear");

        // Reset in the middle of a conversion
        zeraPontos = 1; tick(); zeraPontos = 0;
        tick(); tick();
        reset = 0; tick();
        chk("rst_mid_valido", bcd_valido, 1);
        chk("rst_mid_pontos", pontos, 0);
        chk("rst_mid_digits", bcd_centena * 100 + bcd_dezena * 10 + bcd_unidade, 0);
        reset = 1; tick();
        chk("post_rst_valido", bcd_valido, 1);
        chk("post_rst_erros", erros_rodada, err_m);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/s1_pontuacao.md
Name: s1_pontuacao

Overview:
- Scoring datapath driven by the game control unit: error counter, per-round error memory (MemErro), points register, iterative binary-to-BCD converter.
- Counts wrong moves in the current round and stores that count per round.
- During the end-of-game scoring phase, subtracts a weighted penalty for each stored round from an initial score.
- Presents the score as three BCD digits for the 7-segment displays.

Parameters:
- N_RODADAS, 16, number of rounds = MemErro depth.
- ADDR_W, 4, width of round index (log2 N_RODADAS).
- ERR_W, 4, width of per-round error count.
- PONTOS_INI, 100, score loaded by zeraPontos (0..127).
- PESO, 2, penalty points per recorded error.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset on clock rising edge).
- zeraErro  in  1  clear round error counter.
- contaErro  in  1  increment round error counter.
- zeraMemErro  in  1  clear all MemErro entries.
- regErro  in  1  write error counter into MemErro[endereco].
- endereco  in  ADDR_W  round index (limit-counter value), used for write and read.
- zeraPontos  in  1  load PONTOS_INI into points register.
- regPontos  in  1  apply penalty of MemErro[endereco].
- erros_rodada  out  ERR_W  current error counter value.
- erro_lido  out  ERR_W  MemErro[endereco], combinational read.
- pontos  out  7  points register.
- bcd_centena, bcd_dezena, bcd_unidade  out  4 each  BCD of pontos.
- bcd_valido  out  1  BCD digits match pontos.

Behaviour:
- Reset (reset=0 at edge):
  - errCnt=0, all MemErro=0, pontos=0.
  - BCD digits=0, bcd_valido=1, converter FSM in OCIOSO.
  - Reset overrides every other input, including mid-conversion.
- Error counter:
  - zeraErro has priority: next errCnt=0.
  - Otherwise contaErro increments errCnt, saturating at 2^ERR_W-1 (no wrap).
  - erros_rodada = errCnt.
- MemErro:
  - zeraMemErro clears all entries in one cycle and has priority over regErro.
  - regErro writes errCnt (pre-edge value) to MemErro[endereco].
  - If regErro and contaErro are asserted in the same cycle, the stored value is the pre-increment count.
  - endereco >= N_RODADAS (non-power-of-2 depth): write ignored, read returns 0.
- Points register:
  - zeraPontos has priority: pontos <= PONTOS_INI.
  - Else regPontos: pontos <= pontos - erro_lido*PESO, saturating at 0.
  - Product computed in 7+ERR_W bits; no underflow wrap.
  - pontos changes only on these two controls.
  - Control unit holds endereco stable one cycle before regPontos; combinational read needs no extra latency.
- BCD converter FSM (double-dabble, 7 input bits):
  - OCIOSO: bcd_valido=1. Any cycle where pontos is written (zeraPontos or regPontos) → CONVERTE on the next edge, capturing the new pontos; bcd_valido=0 from that edge.
  - CONVERTE: one shift per cycle with add-3 correction per digit ≥5, 7 cycles; bit counter 0..6.
    - After the 7th shift → PRONTO.
    - A pontos write during CONVERTE restarts: recapture, counter=0, stay CONVERTE.
  - PRONTO: digits registered to outputs atomically, bcd_valido=1 → OCIOSO next cycle.
  - PRONTO with a simultaneous pontos write: outputs still update, then go to CONVERTE.
  - Latency: write edge to bcd_valido=1 is 8 cycles. Digit outputs hold their previous value until PRONTO; no intermediate values are visible.
  - bcd_centena is at most 1 (pontos ≤ 127).
- All outputs are registered except erro_lido.

Test Plan:
- Reset low 2 cycles → pontos=0, digits 0/0/0, bcd_valido=1, erros_rodada=0, erro_lido=0 for every address.
- zeraErro, 3× contaErro, regErro at endereco=2; zeraErro, 20× contaErro, regErro at endereco=5 → MemErro[2]=3, MemErro[5]=15 (saturated).
- zeraPontos, then regPontos with endereco=2 (err 3), then endereco=5 (err 15):
  - pontos 100 → 94 → 64.
  - 8 cycles after the last write, digits 0/6/4 and bcd_valido=1.
- Preload errors so the penalty exceeds the score (endereco 0..15 each 15, PESO=2), iterate regPontos → pontos saturates at 0, never wraps; final digits 0/0/0.
- regPontos 3 cycles after zeraPontos (mid-conversion) → converter restarts; bcd_valido stays 0 until 8 cycles after the second write; final digits match the second value only.
- zeraMemErro and regErro in the same cycle → all entries 0. Drive reset low mid-conversion → bcd_valido=1, pontos=0 next cycle.
